mem_bridge32: RTL
=================

# mem_bridge32

Memory responder for the CPU's 64-bit load/store/fetch bus: accepts one byte/wyde/tetra/octa request at a time from the initiator side (`mem_address`, `mem_datasize`, `mem_read`, `mem_write`, `mem_writedata`) and serves it from a 32-bit synchronous RAM with byte enables. Octas take two RAM beats. Sits between the CPU's merged fetch/execute memory port and on-chip block RAM.

## Interface
- `ADDR_W`, 14: RAM word-address width (RAM holds 2^ADDR_W 32-bit words).
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `mem_address`  in  64  byte address from CPU
- `mem_datasize`  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- `mem_read`  in  1  read request, level, held until `mem_done`
- `mem_write`  in  1  write request, level, held until `mem_done`
- `mem_writedata`  in  64  right-justified store data
- `mem_readdata`  out  64  right-justified, zero-extended load data
- `mem_done`  out  1  one-cycle completion pulse
- `ram_addr`  out  ADDR_W  RAM word address
- `ram_we`  out  1  RAM write strobe
- `ram_byteen`  out  4  byte enables; bit 3 = bits [31:24]
- `ram_wdata`  out  32  RAM write data
- `ram_rdata`  in  32  RAM read data, valid one cycle after `ram_addr`

## Operation
- Alignment follows MMIX: the low log2(size) address bits are ignored. Byte lanes are big-endian: byte offset 0 within a word is `[31:24]`. An octa's high word is at the even word address and its low word at +1.
- Word address is `mem_address[ADDR_W+1:2]`. Octas use `mem_address[ADDR_W+1:3]` with the LSB forced to 0 or 1.
- States: IDLE, RD_HI, RD_LO, RD_LAST, WR_HI, WR_LO, DONE.
- IDLE: samples the request. Address, size and write data are latched on acceptance.
  - If `mem_read` and `mem_write` are both high, the read wins and the write is ignored.
  - Read goes to RD_HI. Write goes to WR_HI.
- RD_HI: issues the first word address.
  - Octa goes to RD_LO. Otherwise goes to RD_LAST.
- RD_LO: issues the low word address and captures the high word into `mem_readdata[63:32]`. Goes to RD_LAST.
- RD_LAST: captures `ram_rdata` and extracts the lane. Result is zero-extended into `mem_readdata`; for an octa, the low half is filled. Goes to DONE.
- WR_HI: asserts `ram_we`. Data is replicated to the addressed lane: byte → all 4 lanes, wyde → both halves.
  - `ram_byteen` selects the lane: byte = one-hot, wyde = 1100/0011, tetra/octa = 1111.
  - Octa writes `mem_writedata[63:32]`, then goes to WR_LO. Otherwise goes to DONE.
- WR_LO: writes `mem_writedata[31:0]` to word+1. Goes to DONE.
- DONE: `mem_done` = 1 for exactly one cycle. Returns to IDLE.
  - The request is not resampled in DONE. The initiator drops or replaces it at the same edge.
- `mem_readdata` holds its value until the next read capture. A write does not disturb it.

## Timing
- All outputs are registered.
- Reset values: `mem_done` 0, `mem_readdata` 0, `ram_we` 0, `ram_byteen` 0, `ram_addr` 0, `ram_wdata` 0. State is IDLE.
- A request is first seen high in IDLE in cycle N. `mem_done` is high in:
  - byte/wyde/tetra read: N+3
  - octa read: N+4
  - sub-octa write: N+2
  - octa write: N+3
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE.
- `ram_we` is high only in WR_HI and WR_LO, one cycle per word.
- Reset mid-operation: the next edge forces reset values and `mem_done` is not asserted.
  - An octa write interrupted after WR_HI leaves the high word written and the low word unwritten. This is acceptable.
- Requests deasserted before `mem_done` are a protocol violation. The block completes the latched operation anyway.

## Configuration
- `MEM_BRIDGE_OOR_EN` defined: out-of-range requests have any nonzero bit in `mem_address[62:ADDR_W+2]`. They skip RAM entirely.
  - Path is IDLE → DONE, so `mem_done` is high at N+1.
  - A read returns `mem_readdata` = 0. A write is dropped with no `ram_we`.
  - Bit 63 is ignored.
- Undefined: upper address bits are ignored. Addresses alias modulo 2^(ADDR_W+2) bytes and the normal latencies apply.

## Test plan
- Tetra write 0x89ABCDEF at address 0x100, then tetra read at 0x103. Required: word 0x40 = 0x89ABCDEF, byteen 1111, read returns 0x0000_0000_89AB_CDEF with done at N+3.
- Byte reads at 0x100..0x103 after that write. Required: 0x89, 0xAB, 0xCD, 0xEF, each zero-extended. Byte write of 0x55 at 0x102 with byteen 0010 then reads back 0x89AB55EF.
- Octa write 0x0123456789ABCDEF at 0x20F. Required: word 0x82 = 0x01234567 and word 0x83 = 0x89ABCDEF in consecutive cycles, done at N+3. Octa read back returns the same value with done at N+4.
- `mem_read` and `mem_write` both high at 0x40. Required: read performed, no `ram_we` pulse, done at N+3.
- `reset` asserted during RD_LO of an octa read. Required: `mem_done` never pulses, all outputs 0 the next cycle, and a subsequent request is served normally.
- With `MEM_BRIDGE_OOR_EN`: read at 0x0000_1000_0000_0000 returns 0 with done at N+1, and a write there produces no `ram_we`. Without the macro, the same read aliases to word 0.

Source files
------------

// File: rtl/mem_bridge32.sv
// mem_bridge32: 64-bit CPU load/store bus responder on a 32-bit byte-enabled synchronous RAM.
//   clk, reset (sync, active-high)
//   CPU side : mem_address, mem_datasize (0 byte,1 wyde,2 tetra,3 octa), mem_read, mem_write,
//              mem_writedata (right-justified) -> mem_readdata (right-justified, zero-extended), mem_done
//   RAM side : ram_addr (word), ram_we, ram_byteen (bit 3 = [31:24]), ram_wdata, ram_rdata (1-cycle latency)
//   Option   : MEM_BRIDGE_OOR_EN completes out-of-range requests immediately without touching RAM.
module mem_bridge32 #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       mem_address,
  input  logic [1:0]        mem_datasize,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [63:0]       mem_writedata,
  output logic [63:0]       mem_readdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, RD_LAST, WR_HI, WR_LO, DONE} state_t;
  state_t              r_state;
  logic [1:0]          r_size;
  logic [1:0]          r_off;
  logic [31:0]         r_wlo;
  logic                w_oor;
  logic                w_unused;
  logic [ADDR_W-1:0]   w_addr0;
  logic [31:0]         w_wdata;
  logic [3:0]          w_be;
  logic [63:0]         w_lane;
`ifdef MEM_BRIDGE_OOR_EN
  assign w_oor = |mem_address[62:ADDR_W+2];
`else
  assign w_oor = 1'b0;
`endif
  assign w_unused = ^mem_address[63:ADDR_W+2];
  // Octas start at the even (high) word; everything else at its own word.
  always_comb begin
    w_addr0 = mem_datasize == 2'd3 ? {mem_address[ADDR_W+1:3], 1'b0} : mem_address[ADDR_W+1:2];
    w_wdata = mem_datasize == 2'd0 ? {4{mem_writedata[7:0]}} :
              mem_datasize == 2'd1 ? {2{mem_writedata[15:0]}} :
              mem_datasize == 2'd2 ? mem_writedata[31:0] : mem_writedata[63:32];
    w_be    = mem_datasize == 2'd0 ? 4'b1000 >> mem_address[1:0] :
              mem_datasize == 2'd1 ? (mem_address[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    // Big-endian lanes: byte offset 0 sits in [31:24].
    w_lane  = r_size == 2'd3 ? {mem_readdata[63:32], ram_rdata} :
              r_size == 2'd2 ? {32'b0, ram_rdata} :
              r_size == 2'd1 ? {48'b0, r_off[1] ? ram_rdata[15:0] : ram_rdata[31:16]} :
                               {56'b0, ram_rdata[{~r_off, 3'b000} +: 8]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_off        <= '0;
      r_wlo        <= '0;
      mem_readdata <= '0;
      mem_done     <= 1'b0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_byteen   <= '0;
      ram_wdata    <= '0;
    end else begin
      mem_done   <= 1'b0;
      ram_we     <= 1'b0;
      ram_byteen <= '0;
      case (r_state)
        IDLE: if (mem_read || mem_write) begin
          r_size <= mem_datasize;
          r_off  <= mem_address[1:0];
          r_wlo  <= mem_writedata[31:0];
          if (w_oor) begin
            r_state  <= DONE;
            mem_done <= 1'b1;
            if (mem_read) mem_readdata <= '0;
          end else begin
            ram_addr <= w_addr0;
            r_state  <= mem_read ? RD_HI : WR_HI;
            if (!mem_read) begin
              ram_we     <= 1'b1;
              ram_byteen <= w_be;
              ram_wdata  <= w_wdata;
            end
          end
        end
        RD_HI: if (r_size == 2'd3) begin
          ram_addr <= {ram_addr[ADDR_W-1:1], 1'b1};
          r_state  <= RD_LO;
        end else r_state <= RD_LAST;
        RD_LO: begin
          mem_readdata[63:32] <= ram_rdata;
          r_state             <= RD_LAST;
        end
        RD_LAST: begin
          mem_readdata <= w_lane;
          mem_done     <= 1'b1;
          r_state      <= DONE;
        end
        WR_HI: if (r_size == 2'd3) begin
          ram_we     <= 1'b1;
          ram_byteen <= 4'hF;
          ram_wdata  <= r_wlo;
          ram_addr   <= {ram_addr[ADDR_W-1:1], 1'b1};
          r_state    <= WR_LO;
        end else begin
          mem_done <= 1'b1;
          r_state  <= DONE;
        end
        WR_LO: begin
          mem_done <= 1'b1;
          r_state  <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
